// File: rtl/cache_pkg.sv
// Shared types and default sizing for the fully-associative cache controller.
package cache_pkg;
  localparam int ENTRIES_DEF = 4;
  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL_REQ,
    FILL_WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/cache_match.sv
// Parallel tag compare with priority encoders for the hit line and lowest invalid line.
module cache_match #(
  parameter int ENTRIES = 4,
  parameter int AW      = 8
) (
  input  logic [ENTRIES-1:0]                 valid,
  input  logic [ENTRIES-1:0][AW-1:0]         tags,
  input  logic [AW-1:0]                      addr,
  output logic                               hit,
  output logic [$clog2(ENTRIES)-1:0]         hit_idx,
  output logic                               inv_any,
  output logic [$clog2(ENTRIES)-1:0]         inv_idx
);
  localparam int IW = $clog2(ENTRIES);

  // Scan from the top down so the lowest index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == addr)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid[i]) begin
        inv_any = 1'b1;
        inv_idx = IW'(i);
      end
    end
  end
endmodule

// File: rtl/assoc_cache_ctrl.sv
// Fully-associative write-back cache controller with round-robin replacement.
// state     | meaning
// IDLE      | ready for a CPU request
// LOOKUP    | compare registered address against all valid tags
// WB        | write dirty victim back to memory
// FILL_REQ  | issue fill read for the request address
// FILL_WAIT | wait for fill data, then install the line
// RESP      | one-cycle response pulse
module assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_hit,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rdata
);
  localparam int IW = $clog2(ENTRIES);

  state_t                     state;
  logic [AW-1:0]              addr_q;
  logic                       we_q;
  logic [DW-1:0]              wdata_q;
  logic [ENTRIES-1:0]         valid_q;
  logic [ENTRIES-1:0]         dirty_q;
  logic [ENTRIES-1:0][AW-1:0] tag_q;
  logic [ENTRIES-1:0][DW-1:0] data_q;
  logic [IW-1:0]              rr_ptr;
  logic [IW-1:0]              vict_q;

  logic          hit;
  logic          inv_any;
  logic [IW-1:0] hit_idx;
  logic [IW-1:0] inv_idx;
  logic [IW-1:0] vict;

  cache_match #(.ENTRIES(ENTRIES), .AW(AW)) u_match (
    .valid   (valid_q),
    .tags    (tag_q),
    .addr    (addr_q),
    .hit     (hit),
    .hit_idx (hit_idx),
    .inv_any (inv_any),
    .inv_idx (inv_idx)
  );

  assign vict = inv_any ? inv_idx : rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      valid_q       <= '0;
      dirty_q       <= '0;
      tag_q         <= '0;
      data_q        <= '0;
      rr_ptr        <= '0;
      vict_q        <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_rdata     <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b1;
            if (we_q) begin
              data_q[hit_idx]  <= wdata_q;
              dirty_q[hit_idx] <= 1'b1;
            end else begin
              rsp_rdata <= data_q[hit_idx];
            end
          end else begin
            vict_q        <= vict;
            mem_req_valid <= 1'b1;
            // Pointer only moves when a live line is displaced.
            if (valid_q[vict]) rr_ptr <= rr_ptr + IW'(1);
            if (valid_q[vict] && dirty_q[vict]) begin
              state     <= WB;
              mem_we    <= 1'b1;
              mem_addr  <= tag_q[vict];
              mem_wdata <= data_q[vict];
            end else begin
              state    <= FILL_REQ;
              mem_addr <= addr_q;
            end
          end
        end
        WB: begin
          if (mem_req_ready) begin
            state     <= FILL_REQ;
            mem_we    <= 1'b0;
            mem_addr  <= addr_q;
            mem_wdata <= '0;
          end
        end
        FILL_REQ: begin
          if (mem_req_ready) begin
            state         <= FILL_WAIT;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
          end
        end
        FILL_WAIT: begin
          if (mem_rsp_valid) begin
            valid_q[vict_q] <= 1'b1;
            tag_q[vict_q]   <= addr_q;
            dirty_q[vict_q] <= we_q;
            data_q[vict_q]  <= we_q ? wdata_q : mem_rdata;
            rsp_valid       <= 1'b1;
            rsp_rdata       <= we_q ? '0 : mem_rdata;
            state           <= RESP;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
